// File: rtl/pagamento_pkg.sv
// Shared types and coin helpers for the payment/change sequencer.
package pagamento_pkg;

  typedef enum logic [2:0] {
    StOcioso,
    StColeta,
    StLibera,
    StTroco,
    StConclui
  } estado_t;

  localparam logic [2:0] MOEDA_5   = 3'd0;
  localparam logic [2:0] MOEDA_10  = 3'd1;
  localparam logic [2:0] MOEDA_25  = 3'd2;
  localparam logic [2:0] MOEDA_50  = 3'd3;
  localparam logic [2:0] MOEDA_100 = 3'd4;

  localparam int unsigned MAX_CREDITO_PADRAO = 1000;

  // Invalid codes map to 0 so callers can gate on moedaValida separately.
  function automatic logic [9:0] valorMoeda(input logic [2:0] codigo);
    case (codigo)
      MOEDA_5:   return 10'd5;
      MOEDA_10:  return 10'd10;
      MOEDA_25:  return 10'd25;
      MOEDA_50:  return 10'd50;
      MOEDA_100: return 10'd100;
      default:   return 10'd0;
    endcase
  endfunction

  function automatic logic moedaValida(input logic [2:0] codigo);
    return codigo <= MOEDA_100;
  endfunction

endpackage

// File: rtl/controle_pagamento_if.sv
// Coin input, ejector handshake and status signals of the payment sequencer.
interface controle_pagamento_if;
  logic       iniciar;
  logic [9:0] preco;
  logic       moeda_valida;
  logic [2:0] moeda_valor;
  logic       cancelar;
  logic       ejetor_ack;
  logic       ejetor_req;
  logic [2:0] ejetor_moeda;
  logic       liberar_produto;
  logic       moeda_devolvida;
  logic       OK;
  logic       vendido;
  logic [9:0] credito;
  logic       ocupado;

  modport master (
    output iniciar, preco, moeda_valida, moeda_valor, cancelar, ejetor_ack,
    input  ejetor_req, ejetor_moeda, liberar_produto, moeda_devolvida, OK, vendido, credito,
           ocupado
  );

  modport slave (
    input  iniciar, preco, moeda_valida, moeda_valor, cancelar, ejetor_ack,
    output ejetor_req, ejetor_moeda, liberar_produto, moeda_devolvida, OK, vendido, credito,
           ocupado
  );
endinterface

// File: rtl/seletor_moeda.sv
// Greedy change selector: largest coin not exceeding the remaining change.
module seletor_moeda
  import pagamento_pkg::*;
(
  input  logic [9:0] troco,
  output logic [2:0] moeda,
  output logic [9:0] valor,
  output logic       troco_zero
);

  always_comb begin
    troco_zero = troco < 10'd5;
    if (troco >= 10'd100)     moeda = MOEDA_100;
    else if (troco >= 10'd50) moeda = MOEDA_50;
    else if (troco >= 10'd25) moeda = MOEDA_25;
    else if (troco >= 10'd10) moeda = MOEDA_10;
    else                      moeda = MOEDA_5;
    valor = valorMoeda(moeda);
  end

endmodule

// File: rtl/controle_pagamento.sv
// Payment and change sequencer: collects coins, releases the product, ejects change.
module controle_pagamento
  import pagamento_pkg::*;
#(
  parameter int unsigned TIMEOUT_CICLOS = 50000,
  parameter int unsigned MAX_CREDITO    = MAX_CREDITO_PADRAO
) (
  input logic                 clk,
  input logic                 rst_n,
  controle_pagamento_if.slave bus
);

  localparam int unsigned   CW          = $clog2(TIMEOUT_CICLOS + 1);
  localparam logic [CW-1:0] TIMEOUT_LIM = CW'(TIMEOUT_CICLOS - 1);
  localparam logic [10:0]   MAX_LIM     = 11'(MAX_CREDITO);

  estado_t       estado;
  logic [9:0]    precoLatch;
  logic [9:0]    troco;
  logic [CW-1:0] contador;
  logic          vendidoFlag;

  logic [2:0]  selMoeda;
  logic [9:0]  selValor;
  logic        selZero;
  logic [9:0]  valorEntrada;
  logic [10:0] somaCredito;
  logic        aceita;
  logic [9:0]  creditoProx;

  seletor_moeda u_seletor (
    .troco      (troco),
    .moeda      (selMoeda),
    .valor      (selValor),
    .troco_zero (selZero)
  );

  // One extra bit so a coin overshooting the ceiling cannot wrap.
  always_comb begin
    valorEntrada = valorMoeda(bus.moeda_valor);
    somaCredito  = {1'b0, bus.credito} + {1'b0, valorEntrada};
    aceita       = bus.moeda_valida && moedaValida(bus.moeda_valor) && (somaCredito <= MAX_LIM);
    creditoProx  = aceita ? somaCredito[9:0] : bus.credito;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado              <= StOcioso;
      precoLatch          <= '0;
      troco               <= '0;
      contador            <= '0;
      vendidoFlag         <= 1'b0;
      bus.ejetor_req      <= 1'b0;
      bus.ejetor_moeda    <= '0;
      bus.liberar_produto <= 1'b0;
      bus.moeda_devolvida <= 1'b0;
      bus.OK              <= 1'b0;
      bus.vendido         <= 1'b0;
      bus.credito         <= '0;
      bus.ocupado         <= 1'b0;
    end else begin
      bus.liberar_produto <= 1'b0;
      bus.OK              <= 1'b0;
      bus.vendido         <= 1'b0;
      bus.moeda_devolvida <= bus.moeda_valida && (estado != StColeta);

      unique case (estado)
        StOcioso: begin
          bus.credito <= '0;
          if (bus.iniciar) begin
            precoLatch  <= bus.preco;
            contador    <= '0;
            bus.ocupado <= 1'b1;
            estado      <= StColeta;
          end
        end

        StColeta: begin
          bus.credito <= creditoProx;
          contador    <= aceita ? '0 : contador + 1'b1;
          if (bus.moeda_valida && !aceita) bus.moeda_devolvida <= 1'b1;
          // A coin arriving with the cancel is credited, then refunded with the rest.
          if (bus.cancelar || contador == TIMEOUT_LIM) begin
            troco       <= creditoProx;
            vendidoFlag <= 1'b0;
            estado      <= StTroco;
          end else if (bus.credito >= precoLatch) begin
            bus.liberar_produto <= 1'b1;
            estado              <= StLibera;
          end
        end

        StLibera: begin
          troco       <= bus.credito - precoLatch;
          vendidoFlag <= 1'b1;
          estado      <= StTroco;
        end

        StTroco: begin
          if (bus.ejetor_req) begin
            if (bus.ejetor_ack) begin
              troco          <= troco - selValor;
              bus.ejetor_req <= 1'b0;
            end
          end else if (selZero) begin
            bus.OK      <= 1'b1;
            bus.vendido <= vendidoFlag;
            estado      <= StConclui;
          end else begin
            bus.ejetor_req   <= 1'b1;
            bus.ejetor_moeda <= selMoeda;
          end
        end

        StConclui: begin
          bus.credito <= '0;
          bus.ocupado <= 1'b0;
          estado      <= StOcioso;
        end

        default: estado <= StOcioso;
      endcase
    end
  end

endmodule

// File: tb/tb_controle_pagamento.sv
// Randomised bench for controle_pagamento with a greedy-change reference model.
module tb_controle_pagamento;

  localparam int unsigned T = 40;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int   nCmp     = 0;
  int   nErr     = 0;
  int   libCount = 0;
  int   okCount  = 0;
  int   devCount = 0;
  int   stabErr  = 0;
  logic prevReq  = 1'b0;
  logic [2:0] prevMoeda = '0;
  int   ejectQ[$];
  int   expQ[$];
  int   ackDelay = 0;
  bit   ackOn    = 1'b1;
  int   waitCnt  = 0;

  always #5 clk = ~clk;

  controle_pagamento_if ifc ();

  controle_pagamento #(
    .TIMEOUT_CICLOS (T),
    .MAX_CREDITO    (1000)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  // Event monitor and coin ejector model, both just after the active edge.
  initial forever begin
    @(posedge clk);
    #1;
    if (ifc.liberar_produto) libCount++;
    if (ifc.OK) okCount++;
    if (ifc.moeda_devolvida) devCount++;
    if (ifc.ejetor_req && prevReq && ifc.ejetor_moeda !== prevMoeda) stabErr++;
    prevReq   = ifc.ejetor_req;
    prevMoeda = ifc.ejetor_moeda;
    if (ackOn && ifc.ejetor_req && !ifc.ejetor_ack) begin
      if (waitCnt >= ackDelay) begin
        ifc.ejetor_ack = 1'b1;
        ejectQ.push_back(int'(ifc.ejetor_moeda));
        waitCnt = 0;
      end else begin
        waitCnt++;
      end
    end else begin
      ifc.ejetor_ack = 1'b0;
      if (!ifc.ejetor_req) waitCnt = 0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  function automatic int valorDe(input int c);
    case (c)
      0: return 5;
      1: return 10;
      2: return 25;
      3: return 50;
      4: return 100;
      default: return 0;
    endcase
  endfunction

  // Expected change as a list of coin codes, largest denomination first.
  function automatic void fillChange(input int amount);
    int den[5];
    int a;
    den = '{100, 50, 25, 10, 5};
    a   = amount;
    expQ.delete();
    for (int i = 0; i < 5; i++) begin
      while (a >= den[i]) begin
        expQ.push_back(4 - i);
        a -= den[i];
      end
    end
  endfunction

  // Order-sensitive fingerprint of a coin list (octal digits code+1).
  function automatic longint sigOf(input int q[$], input int from);
    longint s = 0;
    for (int i = from; i < q.size(); i++) s = s * 8 + longint'(q[i] + 1);
    return s;
  endfunction

  task automatic start(input int p);
    @(negedge clk);
    ifc.iniciar = 1'b1;
    ifc.preco   = 10'(p);
    @(negedge clk);
    ifc.iniciar = 1'b0;
  endtask

  task automatic insert(input int c);
    @(negedge clk);
    ifc.moeda_valida = 1'b1;
    ifc.moeda_valor  = 3'(c);
    @(negedge clk);
    ifc.moeda_valida = 1'b0;
  endtask

  task automatic cancel();
    @(negedge clk);
    ifc.cancelar = 1'b1;
    @(negedge clk);
    ifc.cancelar = 1'b0;
  endtask

  task automatic waitOk(input int budget, output int cyc, output bit hit);
    int base = okCount;
    cyc = 0;
    while (okCount == base && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    hit = (okCount != base);
  endtask

  task automatic test_reset();
    nCmp++;
    if ({ifc.ejetor_req, ifc.ejetor_moeda, ifc.liberar_produto, ifc.moeda_devolvida, ifc.OK,
         ifc.vendido, ifc.credito, ifc.ocupado} !== 19'd0) begin
      nErr++;
      $display("FAIL reset_outputs: got %h expected 0", {ifc.ejetor_req, ifc.ejetor_moeda,
               ifc.liberar_produto, ifc.moeda_devolvida, ifc.OK, ifc.vendido, ifc.credito,
               ifc.ocupado});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    nCmp++;
    if (ifc.ocupado !== 1'b0 || ifc.credito !== 10'd0) begin
      nErr++;
      $display("FAIL reset_idle: got ocupado=%b credito=%0d expected 0/0", ifc.ocupado,
               ifc.credito);
    end
  endtask

  task automatic test_exact();
    int bl = libCount;
    int be = ejectQ.size();
    int cyc;
    bit hit;
    start(150);
    nCmp++;
    if (ifc.ocupado !== 1'b1) begin
      nErr++; $display("FAIL exact_ocupado: got %b expected 1", ifc.ocupado);
    end
    insert(4);
    insert(3);
    nCmp++;
    if (ifc.credito !== 10'd150 || ifc.liberar_produto !== 1'b0) begin
      nErr++;
      $display("FAIL exact_credit: got %0d/%b expected 150/0", ifc.credito, ifc.liberar_produto);
    end
    @(negedge clk);
    nCmp++;
    if (ifc.liberar_produto !== 1'b1) begin
      nErr++; $display("FAIL exact_release_timing: got %b expected 1", ifc.liberar_produto);
    end
    waitOk(100, cyc, hit);
    nCmp++;
    if (!hit || ifc.vendido !== 1'b1) begin
      nErr++; $display("FAIL exact_ok: got ok=%b vendido=%b expected 1/1", hit, ifc.vendido);
    end
    nCmp++;
    if (libCount - bl != 1 || ejectQ.size() - be != 0) begin
      nErr++;
      $display("FAIL exact_events: got rel=%0d ej=%0d expected 1/0", libCount - bl,
               ejectQ.size() - be);
    end
    @(negedge clk);
    nCmp++;
    if (ifc.credito !== 10'd0 || ifc.ocupado !== 1'b0) begin
      nErr++;
      $display("FAIL exact_clear: got %0d/%b expected 0/0", ifc.credito, ifc.ocupado);
    end
  endtask

  task automatic test_change();
    int be = ejectQ.size();
    int bs = stabErr;
    int cyc;
    bit hit;
    ackDelay = 4;
    start(135);
    insert(4);
    insert(3);
    waitOk(300, cyc, hit);
    fillChange(15);
    nCmp++;
    if (!hit || ifc.vendido !== 1'b1) begin
      nErr++; $display("FAIL change_ok: got ok=%b vendido=%b expected 1/1", hit, ifc.vendido);
    end
    nCmp++;
    if (sigOf(ejectQ, be) !== sigOf(expQ, 0)) begin
      nErr++;
      $display("FAIL change_coins: got %o expected %o", sigOf(ejectQ, be), sigOf(expQ, 0));
    end
    nCmp++;
    if (stabErr != bs) begin
      nErr++; $display("FAIL change_stable: got %0d changes expected 0", stabErr - bs);
    end
    ackDelay = 0;
  endtask

  task automatic test_cancel();
    int bl = libCount;
    int be = ejectQ.size();
    int cyc;
    bit hit;
    start(200);
    insert(2);
    insert(1);
    cancel();
    waitOk(200, cyc, hit);
    fillChange(35);
    nCmp++;
    if (!hit || ifc.vendido !== 1'b0) begin
      nErr++; $display("FAIL cancel_ok: got ok=%b vendido=%b expected 1/0", hit, ifc.vendido);
    end
    nCmp++;
    if (sigOf(ejectQ, be) !== sigOf(expQ, 0) || libCount != bl) begin
      nErr++;
      $display("FAIL cancel_coins: got %o rel=%0d expected %o rel=0", sigOf(ejectQ, be),
               libCount - bl, sigOf(expQ, 0));
    end
  endtask

  task automatic test_timeout();
    int be = ejectQ.size();
    int cyc;
    bit hit;
    start(200);
    insert(3);
    waitOk(T + 100, cyc, hit);
    fillChange(50);
    nCmp++;
    if (!hit || ifc.vendido !== 1'b0 || sigOf(ejectQ, be) !== sigOf(expQ, 0)) begin
      nErr++;
      $display("FAIL timeout_credit: got ok=%b vendido=%b coins=%o expected 1/0/%o", hit,
               ifc.vendido, sigOf(ejectQ, be), sigOf(expQ, 0));
    end
    @(negedge clk);
    be = ejectQ.size();
    start(100);
    // T idle COLETA cycles, one TROCO cycle, then OK.
    waitOk(T + 100, cyc, hit);
    nCmp++;
    if (!hit || cyc != int'(T) + 1) begin
      nErr++;
      $display("FAIL timeout_empty_timing: got ok=%b cycles=%0d expected 1/%0d", hit, cyc + 1,
               T + 2);
    end
    nCmp++;
    if (ifc.vendido !== 1'b0 || ejectQ.size() != be) begin
      nErr++;
      $display("FAIL timeout_empty: got vendido=%b ej=%0d expected 0/0", ifc.vendido,
               ejectQ.size() - be);
    end
  endtask

  task automatic test_reject();
    int bd = devCount;
    int be;
    int cyc;
    bit hit;
    @(negedge clk);
    insert(2);
    nCmp++;
    if (ifc.moeda_devolvida !== 1'b1 || ifc.credito !== 10'd0 || ifc.ocupado !== 1'b0) begin
      nErr++;
      $display("FAIL reject_idle: got dev=%b cred=%0d busy=%b expected 1/0/0",
               ifc.moeda_devolvida, ifc.credito, ifc.ocupado);
    end
    start(1000);
    for (int i = 0; i < 9; i++) insert(4);
    insert(3);
    insert(6);
    nCmp++;
    if (ifc.moeda_devolvida !== 1'b1 || ifc.credito !== 10'd950) begin
      nErr++;
      $display("FAIL reject_code6: got dev=%b cred=%0d expected 1/950", ifc.moeda_devolvida,
               ifc.credito);
    end
    insert(4);
    nCmp++;
    if (ifc.moeda_devolvida !== 1'b1 || ifc.credito !== 10'd950) begin
      nErr++;
      $display("FAIL reject_ceiling: got dev=%b cred=%0d expected 1/950", ifc.moeda_devolvida,
               ifc.credito);
    end
    nCmp++;
    if (devCount - bd != 3) begin
      nErr++; $display("FAIL reject_count: got %0d expected 3", devCount - bd);
    end
    be = ejectQ.size();
    cancel();
    waitOk(600, cyc, hit);
    fillChange(950);
    nCmp++;
    if (!hit || sigOf(ejectQ, be) !== sigOf(expQ, 0)) begin
      nErr++;
      $display("FAIL reject_refund: got ok=%b coins=%o expected 1/%o", hit, sigOf(ejectQ, be),
               sigOf(expQ, 0));
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 10; t++) begin
      int price = 5 * int'($urandom_range(0, 60));
      int cred  = 0;
      int devE  = 0;
      int vend;
      int bd    = devCount;
      int bl    = libCount;
      int be    = ejectQ.size();
      int cyc;
      bit hit;
      bit doCancel = ($urandom_range(0, 3) == 0);
      int cancelK  = int'($urandom_range(0, 5));
      ackDelay = int'($urandom_range(0, 3));
      start(price);
      for (int k = 0; k < 40; k++) begin
        int c;
        if (cred >= price || (doCancel && k == cancelK)) break;
        c = int'($urandom_range(0, 7));
        insert(c);
        if (c <= 4 && cred + valorDe(c) <= 1000) cred += valorDe(c);
        else devE++;
        @(negedge clk);
      end
      if (cred < price) begin
        cancel();
        vend = 0;
        fillChange(cred);
      end else begin
        vend = 1;
        fillChange(cred - price);
      end
      waitOk(800, cyc, hit);
      nCmp++;
      if (!hit || ifc.vendido !== vend[0] || sigOf(ejectQ, be) !== sigOf(expQ, 0)) begin
        nErr++;
        $display("FAIL random_txn%0d: got ok=%b vendido=%b coins=%o expected 1/%0d/%o", t, hit,
                 ifc.vendido, sigOf(ejectQ, be), vend, sigOf(expQ, 0));
      end
      nCmp++;
      if (libCount - bl != vend || devCount - bd != devE) begin
        nErr++;
        $display("FAIL random_events%0d: got rel=%0d dev=%0d expected %0d/%0d", t,
                 libCount - bl, devCount - bd, vend, devE);
      end
      @(negedge clk);
    end
    ackDelay = 0;
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    int be;
    int cyc;
    bit hit;
    ackOn = 1'b0;
    start(135);
    insert(4);
    insert(3);
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = ifc.ejetor_req;
    end
    nCmp++;
    if (!seen) begin
      nErr++; $display("FAIL midreset_req: got req=0 expected 1");
    end
    rst_n = 1'b0;
    #1;
    nCmp++;
    if ({ifc.ejetor_req, ifc.ejetor_moeda, ifc.liberar_produto, ifc.moeda_devolvida, ifc.OK,
         ifc.vendido, ifc.credito, ifc.ocupado} !== 19'd0) begin
      nErr++;
      $display("FAIL midreset_outputs: got %h expected 0", {ifc.ejetor_req, ifc.ejetor_moeda,
               ifc.liberar_produto, ifc.moeda_devolvida, ifc.OK, ifc.vendido, ifc.credito,
               ifc.ocupado});
    end
    @(negedge clk);
    rst_n = 1'b1;
    ackOn = 1'b1;
    be    = ejectQ.size();
    start(5);
    nCmp++;
    if (ifc.ocupado !== 1'b1) begin
      nErr++; $display("FAIL midreset_restart: got ocupado=%b expected 1", ifc.ocupado);
    end
    insert(0);
    waitOk(100, cyc, hit);
    nCmp++;
    if (!hit || ifc.vendido !== 1'b1 || ejectQ.size() != be) begin
      nErr++;
      $display("FAIL midreset_sale: got ok=%b vendido=%b ej=%0d expected 1/1/0", hit,
               ifc.vendido, ejectQ.size() - be);
    end
  endtask

  initial begin
    ifc.iniciar      = 1'b0;
    ifc.preco        = '0;
    ifc.moeda_valida = 1'b0;
    ifc.moeda_valor  = '0;
    ifc.cancelar     = 1'b0;
    ifc.ejetor_ack   = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_exact();
    test_change();
    test_cancel();
    test_timeout();
    test_reject();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule

// File: doc/controle_pagamento.md
# controle_pagamento

Payment and change sequencer for the vending machine. Started by the main controller when it enters its comparison state. Accumulates inserted coins against the latched product price, then pulses product release. Dispenses change one coin at a time through the coin-ejector handshake, and signals `OK` back so the main controller returns to its wait state.

## Interface
- `TIMEOUT_CICLOS`, default 50000: idle cycles in COLETA without an accepted coin before an automatic cancel.
- `MAX_CREDITO`, default 1000: credit ceiling in centavos.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `iniciar` in 1: start request from the main controller; sampled only in OCIOSO.
- `preco` in 10: product price in centavos; latched on `iniciar`.
- `moeda_valida` in 1: one-cycle pulse per inserted coin.
- `moeda_valor` in 3: coin code. 0=5, 1=10, 2=25, 3=50, 4=100 centavos; codes 5–7 are invalid.
- `cancelar` in 1: customer cancel (level).
- `ejetor_ack` in 1: coin ejector has released the requested coin.
- `ejetor_req` out 1: eject request.
- `ejetor_moeda` out 3: code of the coin to eject.
- `liberar_produto` out 1: one-cycle product release pulse.
- `moeda_devolvida` out 1: one-cycle pulse; the inserted coin is rejected and routed back mechanically.
- `OK` out 1: one-cycle completion pulse to the main controller.
- `vendido` out 1: valid with `OK`; 1 means the product was released, 0 means cancelled.
- `credito` out 10: current credit, for display.
- `ocupado` out 1: high in any state except OCIOSO.

## Operation
- States:
  - OCIOSO: `credito`=0. On `iniciar`, latch `preco`, clear the timeout counter, go to COLETA.
  - COLETA: accept coins; described in the bullets below.
  - LIBERA: one cycle. `liberar_produto`=1, troco=`credito`-`preco`, set `vendido`, go to TROCO.
  - TROCO: change dispensing; described below.
  - CONCLUI: one cycle. `OK`=1, clear `credito`, go to OCIOSO.
- COLETA, coin acceptance:
  - A valid coin with `credito`+value ≤ `MAX_CREDITO` is added to `credito`.
  - An invalid code, or a coin that would exceed `MAX_CREDITO`, pulses `moeda_devolvida` and leaves `credito` unchanged.
- COLETA, exits (checked on the registered `credito` each cycle):
  - `cancelar` or timeout: troco=`credito`, `vendido`=0, go to TROCO.
  - Otherwise `credito` ≥ latched `preco`: go to LIBERA.
  - Cancel and timeout take priority over the price check.
- TROCO:
  - If troco < 5, go to CONCLUI. A remainder of 1–4 centavos is dropped; prices are required to be multiples of 5.
  - Otherwise select the largest denomination ≤ troco, assert `ejetor_req` with that `ejetor_moeda`.
  - Hold both stable until `ejetor_ack`=1 is sampled with `ejetor_req`=1.
  - On that edge, subtract the value, drop `ejetor_req` for at least one cycle, then reselect.
  - `ejetor_ack` without `ejetor_req` is ignored.
- Coins arriving in any state other than COLETA pulse `moeda_devolvida`.
- A coin and `cancelar` in the same COLETA cycle: the coin is credited first, then returned as change.
- `preco`=0: COLETA → LIBERA after one cycle, with no change.
- `cancelar` outside COLETA is ignored.

## Timing
- All outputs are registered.
- Reset values: all outputs 0, state OCIOSO, troco=0, timeout counter=0.
- Coin accepted at edge N: `credito` updated after N, and `moeda_devolvida` is high in cycle N+1 if the coin is rejected.
- Price reached: LIBERA state, and `liberar_produto` high, in cycle N+2.
- `iniciar` at edge N: `ocupado`=1 from cycle N+1.
- Timeout counter:
  - Increments each COLETA cycle.
  - Cleared on entering COLETA and on each accepted coin.
  - At `TIMEOUT_CICLOS`-1 it forces a cancel.
- Eject handshake: `ejetor_req` rises at least one cycle after entering TROCO; each coin costs at least 2 cycles plus ejector latency.
- `OK` and `vendido` are high for exactly one cycle, the cycle after troco drops below 5.
- `rst_n` asserted mid-operation: immediate return to OCIOSO and all outputs 0. Any pending credit is lost; this is accepted as a mechanical-audit concern.

## Structure
- Package `pagamento_pkg`:
  - state enum;
  - coin code constants (`MOEDA_5` … `MOEDA_100`);
  - a function mapping code → value in centavos;
  - default `MAX_CREDITO`.
- Sub-module `seletor_moeda`: combinational. Input troco (10 bits); outputs the greedy coin code and its value, plus `troco_zero` (troco < 5).

## Test plan
- Price 150, coins 100+50 → `liberar_produto` 2 cycles after the 50, no ejector requests, `OK`=1 with `vendido`=1, `credito` back to 0.
- Price 135, coins 100+50 → change 15: ejections 10 then 5, each held until ack. With ack delayed 4 cycles, `ejetor_moeda` stays stable throughout.
- Price 200, coins 25+10, then `cancelar` → ejections 25, 10; `OK` with `vendido`=0; no `liberar_produto`.
- No coin for `TIMEOUT_CICLOS` cycles after `iniciar` with credit 50 → eject 50, `OK`, `vendido`=0. Same with credit 0 → `OK` the cycle after timeout.
- Invalid code 6, coins in OCIOSO, and a 100 when `credito`=950 → each pulses `moeda_devolvida`; `credito` unchanged.
- `rst_n` low during TROCO with `ejetor_req` high → all outputs 0 immediately; after release, OCIOSO and `iniciar` is accepted normally.
